gl_bram_arbiter: RTL and testbench
==================================

GL_BRAM_ARBITER -- requirements
Module: gl_bram_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of requesters; index 0 = fetch, 1 = decode, 2 = matrix_mul.
REQ-002 Parameter AW, 32, address width.
REQ-003 Parameter DW, 128, read data width (4 x 32-bit words).
REQ-004 Parameter LOCK_MAX, 4, maximum consecutive grants to one locked requester.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req  in  NREQ  per-requester read request; held until granted.
REQ-008 lock  in  NREQ  per-requester burst-hold hint; sampled only while that requester is granted.
REQ-009 addr  in  NREQ*AW  per-requester read address; requester i occupies slice [i*AW +: AW].
REQ-010 gnt  out  NREQ  one-hot grant, registered.
REQ-011 stall  out  NREQ  stall[i] = req[i] & ~gnt[i], combinational.
REQ-012 bram_addr  out  AW  port-B address, registered.
REQ-013 bram_rd  in  DW  port-B read data, valid one cycle after bram_addr.
REQ-014 rd_valid  out  NREQ  one-hot, marks the cycle rd_data belongs to requester i.
REQ-015 rd_data  out  DW  registered copy of bram_rd.

Function
REQ-016 States: IDLE (no grant), GRANT (single access), LOCK (burst held by one requester).
REQ-017 Request sampled at edge N -> gnt and bram_addr updated at N+1 -> rd_valid and rd_data at N+2.
REQ-018 At most one gnt bit and at most one rd_valid bit high in any cycle.
REQ-019 IDLE -> GRANT when any req high; stays IDLE with gnt=0 and bram_addr held otherwise.
REQ-020 GRANT -> LOCK when the granted requester has req and lock high; the count starts at 1.
REQ-021 In LOCK, the grant holds and bram_addr follows addr of the owner every cycle; the count increments.
REQ-022 LOCK exits when the owner drops req or lock, or when count reaches LOCK_MAX; arbitration is then forced among the other requesters first.
REQ-023 From GRANT with no lock, arbitrate again on the next edge; back-to-back grants to different requesters are allowed with no bubble.
REQ-024 Winner selection is given under Configuration; a requester whose req drops before grant is not granted.
REQ-025 The count is LOCK_MAX-bit saturating and never wraps.
REQ-026 rd_valid is a one-cycle-delayed copy of gnt; rd_data is registered from bram_rd every cycle.

Reset
REQ-027 While reset is low: gnt=0, rd_valid=0, bram_addr=0, rd_data=0, state IDLE, count=0, round-robin pointer=0.
REQ-028 Reset asserted mid-burst aborts the burst immediately; no rd_valid is issued after reset is released for accesses granted before it.

Configuration
REQ-029 Macro GL_ARB_RR_EN defined: round-robin arbitration; search starts at the index after the last granted requester.
REQ-030 Macro GL_ARB_RR_EN undefined: fixed priority, lowest index wins; the pointer register is removed.

Structure
REQ-031 State encodings, requester index constants (REQ_FETCH, REQ_DECODE, REQ_MATMUL) and LOCK_MAX default live in gl_defines.v.
REQ-032 Winner selection is one sub-module, gl_arb_pick: req vector and pointer in, one-hot winner out, combinational.

Verification
REQ-033 Single request: req=3'b010, addr1=0x40 at edge 0 -> gnt=3'b010 and bram_addr=0x40 at edge 1 -> rd_valid=3'b010 and rd_data=bram_rd at edge 2.
REQ-034 Contention, RR build: req=3'b111 held -> gnt sequence 001, 010, 100, 001; stall is high for the two losers each cycle.
REQ-035 Contention, fixed build: req=3'b111 held -> gnt=001 every cycle; stall=3'b110 throughout.
REQ-036 Burst cap: req2 and lock2 held for 6 cycles with req0 high -> gnt=100 for exactly 4 cycles, then 001; bram_addr tracks addr2 (0x80, 0x84, 0x88, 0x8C).
REQ-037 Reset mid-burst: reset low during the third locked cycle -> gnt=0, rd_valid=0 the same cycle; after release, no rd_valid occurs until a new grant.
REQ-038 Requester withdraws: req1 pulsed for 1 cycle while req0 is locked -> gnt1 never asserts; no rd_valid for requester 1.

Source files
------------

// File: rtl/gl_bram_arbiter_pkg.sv
// gl_bram_arbiter_pkg -- shared definitions for the BRAM port-B read arbiter.
//   NREQ_DEF / AW_DEF / DW_DEF / LOCK_MAX_DEF : default parameter values
//   REQ_FETCH / REQ_DECODE / REQ_MATMUL      : requester index assignments
//   state_t                                  : arbiter FSM states
//   idx_width()                              : index width for an n-entry vector
package gl_bram_arbiter_pkg;

    localparam int NREQ_DEF     = 3;
    localparam int AW_DEF       = 32;
    localparam int DW_DEF       = 128;
    localparam int LOCK_MAX_DEF = 4;

    localparam int REQ_FETCH  = 0;
    localparam int REQ_DECODE = 1;
    localparam int REQ_MATMUL = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    // Never returns 0 so index vectors stay legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gl_bram_arbiter_if.sv
// gl_bram_arbiter_if -- requester/BRAM bus of the port-B read arbiter.
//   req, lock, addr : per-requester request, burst-hold hint, read address
//                     (requester i at addr[i*AW +: AW])
//   gnt, stall      : one-hot registered grant, combinational stall
//   rd_valid, rd_data : one-hot owner tag and registered read data
//   bram_addr, bram_rd : BRAM port-B address (registered) and read data
//   modport slave  : arbiter side
//   modport master : requesters + BRAM side
interface gl_bram_arbiter_if
    import gl_bram_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    stall;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;
    logic [AW-1:0]      bram_addr;
    logic [DW-1:0]      bram_rd;

    modport slave (
        input  req, lock, addr, bram_rd,
        output gnt, stall, rd_valid, rd_data, bram_addr
    );

    modport master (
        output req, lock, addr, bram_rd,
        input  gnt, stall, rd_valid, rd_data, bram_addr
    );

endinterface

// File: rtl/gl_arb_pick.sv
// gl_arb_pick -- combinational winner selection.
//   req : candidate request vector
//   ptr : index where the search starts (0 gives lowest-index-wins)
//   gnt : one-hot winner, all-zero when req is zero
// Must be driven with ptr < NREQ.
module gl_arb_pick
    import gl_bram_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic [NREQ-1:0] req_rot;
    logic [NREQ-1:0] gnt_rot;

    // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_rot = NREQ'({req, req} >> ptr);
        gnt_rot = req_rot & (~req_rot + NREQ'(1));
        gnt     = NREQ'(({gnt_rot, gnt_rot} << ptr) >> NREQ);
    end

endmodule

// File: rtl/gl_bram_arbiter.sv
// gl_bram_arbiter -- arbitrates NREQ read requesters onto one BRAM read port.
//   clk   : single clock, posedge
//   reset : asynchronous active-low reset
//   bus   : gl_bram_arbiter_if.slave (req/lock/addr in, gnt/stall out,
//           bram_addr out / bram_rd in, rd_valid/rd_data out)
// Request sampled at edge N -> gnt/bram_addr at N+1 -> rd_valid/rd_data at N+2.
// A granted requester holding lock keeps the port for up to LOCK_MAX
// consecutive cycles; on exit the other requesters are considered first.
// Build option: define GL_ARB_RR_EN for round-robin arbitration; left
// undefined the arbiter is fixed priority (index 0 highest) with no pointer.
module gl_bram_arbiter
    import gl_bram_arbiter_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    gl_bram_arbiter_if.slave   bus
);

    localparam int IW = idx_width(NREQ);
    localparam int CW = LOCK_MAX;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_CAP = CW'(LOCK_MAX);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   count_q, count_d, count_inc;
    logic [NREQ-1:0] rd_valid_q;
    logic [DW-1:0]   rd_data_q;

    logic [NREQ-1:0] others;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] pick_oh;
    logic [AW-1:0]   pick_addr;
    logic [AW-1:0]   owner_addr;
    logic [IW-1:0]   ptr_cur;
    logic            owner_hold;
    logic            do_arb;
    logic            take_pick;

    // Owner still wants the burst (gnt_q is one-hot or zero).
    assign owner_hold = |(gnt_q & bus.req & bus.lock);
    assign count_inc  = (&count_q) ? count_q : count_q + CNT_ONE;

    // Leaving a burst: the other requesters go first when any are waiting.
    assign others  = bus.req & ~gnt_q;
    assign arb_req = ((state_q == ST_LOCK) && (|others)) ? others : bus.req;

    gl_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req (arb_req),
        .ptr (ptr_cur),
        .gnt (pick_oh)
    );

    always_comb begin
        pick_addr  = '0;
        owner_addr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pick_addr  |= bus.addr[i*AW +: AW] & {AW{pick_oh[i]}};
            owner_addr |= bus.addr[i*AW +: AW] & {AW{gnt_q[i]}};
        end
    end

`ifdef GL_ARB_RR_EN
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] pick_idx;

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pick_idx |= IW'(i) & {IW{pick_oh[i]}};
        end
    end

    // Next search starts just after the requester that last won.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (take_pick) begin
            ptr_q <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
        end
    end

    assign ptr_cur = ptr_q;
`else
    assign ptr_cur = '0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        count_d   = count_q;
        do_arb    = 1'b0;
        take_pick = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_arb = 1'b1;
            end
            ST_GRANT: begin
                if (owner_hold && (LOCK_MAX > 1)) begin
                    state_d = ST_LOCK;
                    count_d = CNT_ONE;
                    addr_d  = owner_addr;
                end else begin
                    do_arb = 1'b1;
                end
            end
            ST_LOCK: begin
                // GRANT cycle plus count locked cycles = consecutive grants.
                if (owner_hold && (count_inc != CNT_CAP)) begin
                    count_d = count_inc;
                    addr_d  = owner_addr;
                end else begin
                    do_arb = 1'b1;
                end
            end
            default: begin
                do_arb = 1'b1;
            end
        endcase

        if (do_arb) begin
            if (|arb_req) begin
                state_d   = ST_GRANT;
                gnt_d     = pick_oh;
                addr_d    = pick_addr;
                count_d   = '0;
                take_pick = 1'b1;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_valid_q <= gnt_q;
            rd_data_q  <= bus.bram_rd;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.stall     = bus.req & ~gnt_q;
    assign bus.bram_addr = addr_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_gl_bram_arbiter.sv
module tb_gl_bram_arbiter;
    import gl_bram_arbiter_pkg::*;

    localparam int NREQ     = 3;
    localparam int AW       = 32;
    localparam int DW       = 128;
    localparam int LOCK_MAX = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [NREQ-1:0] req_v  = '0;
    logic [NREQ-1:0] lock_v = '0;
    logic [AW-1:0]   addr_v [NREQ];

    int checks   = 0;
    int failures = 0;

    // Reference model: current owner, length of its current run of grants,
    // last winner, and the expected registered outputs.
    int              owner;
    int              run_len;
    int              last;
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] exp_rdv;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_rdd;

    gl_bram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    gl_bram_arbiter #(
        .NREQ     (NREQ),
        .AW       (AW),
        .DW       (DW),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bram_model(input logic [AW-1:0] a);
        return {a ^ 32'hDEAD_BEEF, a + 32'h1111_1111, ~a, a};
    endfunction

    assign bus.req     = req_v;
    assign bus.lock    = lock_v;
    assign bus.addr    = {addr_v[REQ_MATMUL], addr_v[REQ_DECODE], addr_v[REQ_FETCH]};
    assign bus.bram_rd = bram_model(bus.bram_addr);

    function automatic int pick_from(input logic [NREQ-1:0] cand, input int start);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (start + k) % NREQ;
            if (cand[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner    = -1;
        run_len  = 0;
        last     = NREQ - 1;
        exp_gnt  = '0;
        exp_rdv  = '0;
        exp_addr = '0;
        exp_rdd  = '0;
    endtask

    // One rising edge of the specified behaviour, from the current inputs.
    task automatic model_edge();
        logic [NREQ-1:0] cand;
        logic [NREQ-1:0] rest;
        int w;
        exp_rdv = exp_gnt;
        exp_rdd = bram_model(exp_addr);
        if (owner >= 0 && req_v[owner] && lock_v[owner] && run_len < LOCK_MAX) begin
            run_len++;
            exp_addr = addr_v[owner];
        end else begin
            cand = req_v;
            if (owner >= 0 && run_len >= 2) begin
                rest = req_v & ~(NREQ'(1) << owner);
                if (rest != '0) cand = rest;
            end
`ifdef GL_ARB_RR_EN
            w = pick_from(cand, (last + 1) % NREQ);
`else
            w = pick_from(cand, 0);
`endif
            if (w >= 0) begin
                owner    = w;
                run_len  = 1;
                last     = w;
                exp_addr = addr_v[w];
            end else begin
                owner   = -1;
                run_len = 0;
            end
        end
        exp_gnt = (owner >= 0) ? (NREQ'(1) << owner) : '0;
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        req_v  = '0;
        lock_v = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        req_v  = 3'b101;
        lock_v = '0;
        @(negedge clk);
        checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b expected 000", bus.gnt); end
        checks++; if (bus.rd_valid !== 3'b000) begin failures++; $display("FAIL reset_rd_valid: got %b expected 000", bus.rd_valid); end
        checks++; if (bus.bram_addr !== '0) begin failures++; $display("FAIL reset_bram_addr: got %h expected 0", bus.bram_addr); end
        checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
        checks++; if (bus.stall !== 3'b101) begin failures++; $display("FAIL reset_stall: got %b expected 101", bus.stall); end
        req_v = '0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_v = 3'b010;
        addr_v[REQ_DECODE] = 32'h40;
        #1;
        checks++; if (bus.stall !== 3'b010) begin failures++; $display("FAIL single_stall: got %b expected 010", bus.stall); end
        advance();
        checks++; if (bus.gnt !== 3'b010) begin failures++; $display("FAIL single_gnt: got %b expected 010", bus.gnt); end
        checks++; if (bus.bram_addr !== 32'h40) begin failures++; $display("FAIL single_addr: got %h expected 40", bus.bram_addr); end
        checks++; if (bus.rd_valid !== exp_rdv) begin failures++; $display("FAIL single_rdv_early: got %b expected %b", bus.rd_valid, exp_rdv); end
        @(negedge clk);
        req_v = '0;
        advance();
        checks++; if (bus.rd_valid !== 3'b010) begin failures++; $display("FAIL single_rdv: got %b expected 010", bus.rd_valid); end
        checks++; if (bus.rd_data !== bram_model(32'h40)) begin failures++; $display("FAIL single_rdata: got %h expected %h", bus.rd_data, bram_model(32'h40)); end
        checks++; if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL single_gnt_drop: got %b expected %b", bus.gnt, exp_gnt); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] want;
`ifdef GL_ARB_RR_EN
        logic [NREQ-1:0] rr_seq [4];
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        do_reset();
        req_v  = '1;
        lock_v = '0;
        for (int i = 0; i < 4; i++) begin
            addr_v[REQ_FETCH]  = AW'(32'h1000 + i);
            addr_v[REQ_DECODE] = AW'(32'h2000 + i);
            addr_v[REQ_MATMUL] = AW'(32'h3000 + i);
            advance();
`ifdef GL_ARB_RR_EN
            want = rr_seq[i];
`else
            want = 3'b001;
`endif
            checks++; if (bus.gnt !== want) begin failures++; $display("FAIL contend_gnt[%0d]: got %b expected %b", i, bus.gnt, want); end
            checks++; if (bus.stall !== (req_v & ~want)) begin failures++; $display("FAIL contend_stall[%0d]: got %b expected %b", i, bus.stall, req_v & ~want); end
            checks++; if (bus.bram_addr !== exp_addr) begin failures++; $display("FAIL contend_addr[%0d]: got %h expected %h", i, bus.bram_addr, exp_addr); end
            checks++; if (bus.rd_valid !== exp_rdv) begin failures++; $display("FAIL contend_rdv[%0d]: got %b expected %b", i, bus.rd_valid, exp_rdv); end
            checks++; if (bus.rd_data !== exp_rdd) begin failures++; $display("FAIL contend_rdata[%0d]: got %h expected %h", i, bus.rd_data, exp_rdd); end
            @(negedge clk);
        end
    endtask

    task automatic test_burst_cap();
        logic [NREQ-1:0] want_g;
        logic [AW-1:0]   want_a;
        do_reset();
        lock_v = 3'b100;
        addr_v[REQ_FETCH] = 32'h200;
        for (int i = 0; i < 6; i++) begin
            req_v = (i == 0) ? 3'b100 : 3'b101;
            addr_v[REQ_MATMUL] = AW'(32'h80 + 4 * i);
            advance();
            want_g = exp_gnt;
            want_a = exp_addr;
            if (i < 4) begin
                want_g = 3'b100;
                want_a = AW'(32'h80 + 4 * i);
            end else if (i == 4) begin
                want_g = 3'b001;
                want_a = 32'h200;
            end
            checks++; if (bus.gnt !== want_g) begin failures++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, bus.gnt, want_g); end
            checks++; if (bus.bram_addr !== want_a) begin failures++; $display("FAIL burst_addr[%0d]: got %h expected %h", i, bus.bram_addr, want_a); end
            checks++; if (bus.rd_valid !== exp_rdv) begin failures++; $display("FAIL burst_rdv[%0d]: got %b expected %b", i, bus.rd_valid, exp_rdv); end
            checks++; if (bus.rd_data !== exp_rdd) begin failures++; $display("FAIL burst_rdata[%0d]: got %h expected %h", i, bus.rd_data, exp_rdd); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_v  = 3'b001;
        lock_v = 3'b001;
        for (int i = 0; i < 4; i++) begin
            addr_v[REQ_FETCH] = AW'(32'h100 + 4 * i);
            advance();
            checks++; if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL midrst_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_gnt); end
            @(negedge clk);
        end
        // Third locked cycle: pull reset without waiting for a clock edge.
        reset = 1'b0;
        #1;
        checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL midrst_async_gnt: got %b expected 000", bus.gnt); end
        checks++; if (bus.rd_valid !== 3'b000) begin failures++; $display("FAIL midrst_async_rdv: got %b expected 000", bus.rd_valid); end
        checks++; if (bus.bram_addr !== '0) begin failures++; $display("FAIL midrst_async_addr: got %h expected 0", bus.bram_addr); end
        @(negedge clk);
        req_v  = '0;
        lock_v = '0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++; if (bus.rd_valid !== 3'b000) begin failures++; $display("FAIL midrst_stale_rdv[%0d]: got %b expected 000", i, bus.rd_valid); end
            checks++; if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL midrst_idle_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_gnt); end
            @(negedge clk);
        end
        req_v = 3'b010;
        addr_v[REQ_DECODE] = 32'h44;
        advance();
        checks++; if (bus.gnt !== 3'b010) begin failures++; $display("FAIL midrst_new_gnt: got %b expected 010", bus.gnt); end
        @(negedge clk);
        req_v = '0;
        advance();
        checks++; if (bus.rd_valid !== 3'b010) begin failures++; $display("FAIL midrst_new_rdv: got %b expected 010", bus.rd_valid); end
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        bit seen;
        seen = 1'b0;
        do_reset();
        lock_v = 3'b001;
        addr_v[REQ_FETCH]  = 32'h500;
        addr_v[REQ_DECODE] = 32'h600;
        for (int i = 0; i < 8; i++) begin
            req_v = (i == 2) ? 3'b011 : 3'b001;
            advance();
            if (bus.gnt[REQ_DECODE] || bus.rd_valid[REQ_DECODE]) seen = 1'b1;
            checks++; if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL withdraw_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_gnt); end
            checks++; if (bus.rd_valid !== exp_rdv) begin failures++; $display("FAIL withdraw_rdv[%0d]: got %b expected %b", i, bus.rd_valid, exp_rdv); end
            @(negedge clk);
        end
        checks++; if (seen) begin failures++; $display("FAIL withdraw_req1: got grant/rd_valid for requester 1, expected none"); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_v  = NREQ'($urandom);
            lock_v = ($urandom_range(0, 3) != 0) ? NREQ'($urandom) : '0;
            for (int r = 0; r < NREQ; r++) addr_v[r] = $urandom;
            #1;
            checks++; if (bus.stall !== (req_v & ~exp_gnt)) begin failures++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, bus.stall, req_v & ~exp_gnt); end
            advance();
            checks++; if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_gnt); end
            checks++; if (bus.bram_addr !== exp_addr) begin failures++; $display("FAIL rand_addr[%0d]: got %h expected %h", i, bus.bram_addr, exp_addr); end
            checks++; if (bus.rd_valid !== exp_rdv) begin failures++; $display("FAIL rand_rdv[%0d]: got %b expected %b", i, bus.rd_valid, exp_rdv); end
            checks++; if (bus.rd_data !== exp_rdd) begin failures++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, bus.rd_data, exp_rdd); end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int r = 0; r < NREQ; r++) addr_v[r] = '0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_burst_cap();
        test_reset_mid_burst();
        test_withdraw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
